// File: rtl/disp_scan_mux_if.sv
// rtl/disp_scan_mux_if.sv - value/load input bundle and scanned display outputs of disp_scan_mux
//
// Purpose: groups the display scanner's data-path signals so that the producer
// (the core or a testbench) and the scanner connect through one port.
// Signals:
//   value_in    hex value to display, nibble i -> digit i (0 = rightmost)
//   load        capture value_in into the pending register this cycle
//   digit_out   nibble of the active digit, to the segment decoder
//   an_n        active-low anode enables, at most one bit low
//   frame_tick  one-cycle pulse when the scan wraps to digit 0
// Modports:
//   master      drives value_in/load, observes the display outputs
//   slave       the scanner itself

interface disp_scan_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic [3:0]              digit_out;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_tick;

    modport master (
        output value_in,
        output load,
        input  digit_out,
        input  an_n,
        input  frame_tick
    );

    modport slave (
        input  value_in,
        input  load,
        output digit_out,
        output an_n,
        output frame_tick
    );
endinterface

// File: rtl/disp_scan_mux.sv
// rtl/disp_scan_mux.sv - time-multiplexed scanner for a common-anode multi-digit 7-segment display
//
// Purpose: walks the digits one slot at a time, presenting the active nibble on
// digit_out and driving the matching active-low anode. New values are staged in
// a pending register and only take effect at a frame boundary, so a frame is
// never drawn with a mix of old and new nibbles. Optional leading-zero blanking
// and an all-anodes-off gap at the start of every slot (anti-ghosting).
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of disp_scan_mux_if (value_in, load in;
//          digit_out, an_n, frame_tick out, all registered)

module disp_scan_mux #(
    parameter int NUM_DIGITS    = 8,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYC     = 500,
    parameter int BLANK_LEADING = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    disp_scan_mux_if.slave  bus
);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [VW-1:0]       r_shown;
    logic [VW-1:0]       r_pending;
    logic                r_pend_v;
    logic [3:0]          r_digit;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic                r_tick;

    logic                w_slot_end;
    logic                w_last_digit;
    logic                w_boundary;
    logic                w_gap;
    logic                w_blank;
    logic [VW-1:0]       w_upper;
    logic [3:0]          w_nibble;
    logic [NUM_DIGITS-1:0] w_an_next;

    assign w_slot_end   = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));
    assign w_boundary   = w_slot_end && w_last_digit;

    // Anti-ghosting gap: the first BLANK_CYC cycles of each slot keep all
    // anodes off, so the previous digit's segments have settled before the
    // next anode turns on.
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign w_gap = 1'b0;
        end else begin : g_gap
            assign w_gap = (r_presc < PW'(BLANK_CYC));
        end
    endgenerate

    // Nibbles from the active digit upwards; if they are all zero the active
    // digit is a leading zero. Digit 0 always lights so 0 shows as "0".
    assign w_upper  = r_shown >> {r_idx, 2'b00};
    assign w_nibble = r_shown[{r_idx, 2'b00} +: 4];
    assign w_blank  = (BLANK_LEADING != 0) && (r_idx != '0) && (w_upper == '0);

    always_comb begin
        w_an_next = '1;
        if (!w_gap && !w_blank) begin
            w_an_next[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_shown   <= '0;
            r_pending <= '0;
            r_pend_v  <= 1'b0;
            r_digit   <= '0;
            r_an_n    <= '1;
            r_tick    <= 1'b0;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + PW'(1);
            if (w_slot_end) begin
                r_idx <= w_last_digit ? '0 : r_idx + IW'(1);
            end

            // A load coinciding with the boundary bypasses the pending stage
            // so it appears in the very next frame.
            if (w_boundary && bus.load) begin
                r_shown <= bus.value_in;
            end else if (w_boundary && r_pend_v) begin
                r_shown <= r_pending;
            end

            if (bus.load) begin
                r_pending <= bus.value_in;
            end

            if (w_boundary) begin
                r_pend_v <= 1'b0;
            end else if (bus.load) begin
                r_pend_v <= 1'b1;
            end

            r_digit <= w_nibble;
            r_an_n  <= w_an_next;
            r_tick  <= w_boundary;
        end
    end

    assign bus.digit_out  = r_digit;
    assign bus.an_n       = r_an_n;
    assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_disp_scan_mux.sv
// tb/tb_disp_scan_mux.sv - scoreboard testbench for disp_scan_mux

module tb_disp_scan_mux;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int FR = ND * RD;

    typedef struct packed {
        logic [3:0]    d;
        logic [ND-1:0] an;
        logic          ft;
    } exp_t;

    typedef struct packed {
        int          edge_i;
        logic [15:0] val;
    } load_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    disp_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    disp_scan_mux #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYC    (BC),
        .BLANK_LEADING(1)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    exp_t  exp_q[$];
    load_t load_log[$];
    int    edge_cnt = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    mon_cyc = 0;

    // Value on display in the state reached after k clock edges since reset:
    // the most recent load sampled at or before the last frame-boundary edge
    // strictly preceding k; zero if no boundary has passed yet.
    function automatic logic [15:0] model_shown(int k);
        int b;
        if (k < FR) return 16'h0000;
        b = (k / FR) * FR - 1;
        for (int i = load_log.size() - 1; i >= 0; i--) begin
            if (load_log[i].edge_i <= b) return load_log[i].val;
        end
        return 16'h0000;
    endfunction

    function automatic exp_t model_out(int k);
        exp_t        e;
        logic [15:0] sh;
        logic [15:0] up;
        int          slot_pos;
        int          dig;
        sh       = model_shown(k);
        slot_pos = k % RD;
        dig      = (k / RD) % ND;
        up       = sh >> (4 * dig);
        e.d      = up[3:0];
        e.an     = '1;
        if (slot_pos >= BC && !(dig > 0 && up == 16'h0000)) e.an[dig] = 1'b0;
        e.ft     = ((k + 1) % FR == 0);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt = 0;
            load_log.delete();
            exp_q.delete();
        end else begin
            exp_q.push_back(model_out(edge_cnt));
            if (bus.load) load_log.push_back('{edge_cnt, bus.value_in});
            edge_cnt++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.digit_out !== e.d || bus.an_n !== e.an || bus.frame_tick !== e.ft) begin
                n_bad++;
                $display("FAIL cycle%0d: digit_out=%h an_n=%b frame_tick=%b, expected %h %b %b",
                         mon_cyc, bus.digit_out, bus.an_n, bus.frame_tick, e.d, e.an, e.ft);
            end
            n_cmp++;
            if ($countones(~bus.an_n) > 1) begin
                n_bad++;
                $display("FAIL onehot cycle%0d: an_n=%b, expected at most one low bit", mon_cyc, bus.an_n);
            end
            mon_cyc++;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(logic [15:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    // Leaves the bench at a negedge whose following rising edge is a frame boundary.
    task automatic wait_pre_boundary();
        int   i;
        logic found;
        found = 1'b0;
        for (i = 0; i < FR + 2; i++) begin
            if ((edge_cnt + 1) % FR == 0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL boundary_wait: no boundary within %0d cycles, expected one", FR + 2);
        end
    endtask

    initial begin
        logic found;
        bus.value_in = '0;
        bus.load     = 1'b0;
        rst_n        = 1'b0;
        cyc(3);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Load right after reset: first frame 0, next frame 1234.
        do_load(16'h1234);
        cyc(2 * FR + 4);

        // Leading-zero blanking.
        do_load(16'h0050);
        cyc(2 * FR + 2);
        do_load(16'h0000);
        cyc(2 * FR);

        // Two loads in one frame: only the last is ever shown.
        wait_pre_boundary();
        cyc(5);
        do_load(16'hAAAA);
        cyc(2);
        do_load(16'hBBBB);
        cyc(2 * FR);

        // Load on the boundary edge, then one cycle later.
        wait_pre_boundary();
        do_load(16'hC0DE);
        do_load(16'h1111);
        cyc(3 * FR);

        // Reset while digit 2 is lit.
        found = 1'b0;
        for (int i = 0; i < FR + 2; i++) begin
            if (((edge_cnt - 1) / RD) % ND == 2 && (edge_cnt - 1) % RD >= BC) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found || bus.an_n !== 4'b1011) begin
            n_bad++;
            $display("FAIL pre_reset_digit2: an_n=%b, expected 1011", bus.an_n);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.an_n !== 4'b1111 || bus.frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: an_n=%b frame_tick=%b, expected 1111 0", bus.an_n, bus.frame_tick);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(2 * FR);

        // Random loads.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.value_in = 16'($urandom);
            bus.load     = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        bus.load = 1'b0;
        cyc(2 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
